pe_row_drain: RTL and testbench
===============================

// Module: pe_row_drain
// PURPOSE
//  Drain-side controller at the tail of a horizontal PE row (output-stationary chain).
//  On drain_start it latches every PE's psum into the output chain (clearing psums),
//  shifts the chain N_PE times and captures the tail word each shift.
//  Captured words go into a FIFO and leave on a valid/ready stream to the ofmap buffer.
// PARAMETERS
//  DW         16  data width of psum/chain words (signed, passed through unmodified)
//  N_PE        8  PEs in the chain (>=2)
//  FIFO_DEPTH 16  capture FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous, active-high reset
//  drain_start    in   1      1-cycle request: accumulation of current tile finished
//  drain_busy     out  1      high from LOAD until the last word is captured
//  drain_done     out  1      1-cycle pulse after the last capture
//  err_overrun    out  1      1-cycle pulse: drain_start seen while not IDLE
//  pe_en_out      out  1      to all PEs' en_out
//  pe_eject_ctrl  out  1      to all PEs' output_eject_ctrl (0=load psum, 1=shift)
//  pe_clear_psum  out  1      to all PEs' clear_psum
//  chain_tail     in   DW     output_out of PE N_PE-1 (PE0 output_in tied to 0)
//  m_data         out  DW     stream word
//  m_idx          out  clog2(N_PE)  source PE index of m_data
//  m_last         out  1      high on word from PE0 (last of tile)
//  m_valid        out  1      stream valid
//  m_ready        in   1      stream ready; transfer when m_valid & m_ready
//  fifo_count     out  clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, counters 0; rst mid-drain aborts, data lost.
//  FSM IDLE -> LOAD (drain_start) -> SHIFT -> IDLE (N_PE words captured).
//  IDLE: PE controls 0. drain_start ignored only outside IDLE (err_overrun pulses, no effect).
//  LOAD (exactly 1 cycle): pe_en_out=1, pe_eject_ctrl=0, pe_clear_psum=1; drain_busy=1.
//   PE output_regs get old psums at this edge while psums clear for the next tile.
//  SHIFT: sample counter k=0..N_PE-1; chain_tail holds psum of PE (N_PE-1-k).
//   Non-stall cycle (fifo_count<FIFO_DEPTH): push {chain_tail, idx=N_PE-1-k, last=(k==N_PE-1)},
//   pe_en_out=1, pe_eject_ctrl=1, k++. Stall cycle (FIFO full): no push, pe_en_out=0
//   (chain holds), k unchanged. pe_clear_psum=0 throughout SHIFT.
//   Full FIFO accepts no push even if a pop occurs same cycle (no pass-through).
//  After push with k==N_PE-1: next cycle drain_done=1, drain_busy=0, FSM=IDLE.
//  drain_start in that done cycle is accepted (back-to-back tiles, LOAD next cycle).
//  No-stall timing, start sampled edge 0: LOAD cycle 1; pushes at edges 2..N_PE+1;
//   m_valid high from cycle 3; drain_done in cycle N_PE+2.
//  FIFO: registered outputs, m_data/m_idx/m_last = head entry, m_valid = (count!=0).
//   Simultaneous push+pop (not full) leaves count unchanged; pop on empty impossible.
//   Stream continues after drain_done until FIFO empty; m_data stable while m_valid&!m_ready.
//  Pointers wrap modulo FIFO_DEPTH; count saturates logically at FIFO_DEPTH via full check.
// TESTING
//  1 N_PE=8, psums 1..8 (PE0..PE7), m_ready=1 -> stream 8,7,..,1, m_idx 7..0, m_last only on 1.
//  2 Timing: start at edge 0 -> LOAD cycle 1, m_valid cycle 3, drain_done cycle 10, clear_psum 1 cycle.
//  3 FIFO_DEPTH=4, m_ready=0 -> 4 pushes then pe_en_out=0 stall; raise m_ready -> all 8 words, in order.
//  4 drain_start during SHIFT -> err_overrun 1 cycle, sequence unchanged; start in done cycle -> LOAD next.
//  5 Negative psums (-1, -32768) -> bit-exact on m_data; push+pop at count=2 keeps count=2.
//  6 rst asserted mid-SHIFT (k=3) -> async: m_valid=0, busy=0, all PE controls 0, FIFO empty.

Source files
------------

// File: rtl/pe_row_drain_if.sv
// rtl/pe_row_drain_if.sv - captured-word stream from the drain controller to the ofmap buffer
interface pe_row_drain_if #(
  parameter int DW = 16,
  parameter int IW = 3
);
  logic [DW-1:0] data;
  logic [IW-1:0] idx;
  logic          last;
  logic          valid;
  logic          ready;

  modport master (output data, idx, last, valid, input ready);
  modport slave  (input data, idx, last, valid, output ready);
endinterface

// File: rtl/pe_row_drain.sv
// rtl/pe_row_drain.sv - tail-of-row drain controller: load psums, shift chain, capture into FIFO, stream out
module pe_row_drain #(
  parameter int DW         = 16,
  parameter int N_PE       = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int IW        = $clog2(N_PE),
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          drain_start,
  output logic          drain_busy,
  output logic          drain_done,
  output logic          err_overrun,
  output logic          pe_en_out,
  output logic          pe_eject_ctrl,
  output logic          pe_clear_psum,
  input  logic [DW-1:0] chain_tail,
  pe_row_drain_if.master m,
  output logic [CW-1:0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] k;
  logic          full, push, pop, last_k;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem_data [FIFO_DEPTH];
  logic [IW-1:0] mem_idx  [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];

  assign full   = (fifo_count == CW'(FIFO_DEPTH));
  assign push   = (state == SHIFT) && !full;
  assign pop    = m.valid && m.ready;
  assign last_k = (k == IW'(N_PE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drain_start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (push && last_k) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO stalls the chain: without en_out the PEs hold their output regs.
  always_comb begin
    drain_busy    = 1'b0;
    pe_en_out     = 1'b0;
    pe_eject_ctrl = 1'b0;
    pe_clear_psum = 1'b0;
    case (state)
      LOAD: begin
        drain_busy    = 1'b1;
        pe_en_out     = 1'b1;
        pe_clear_psum = 1'b1;
      end
      SHIFT: begin
        drain_busy    = 1'b1;
        pe_en_out     = !full;
        pe_eject_ctrl = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k           <= '0;
      drain_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      drain_done  <= push && last_k;
      err_overrun <= drain_start && (state != IDLE);
      if (state == LOAD) k <= '0;
      else if (push)     k <= k + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_idx[i]  <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= chain_tail;
        mem_idx[wr_ptr]  <= IW'(N_PE - 1) - k;
        mem_last[wr_ptr] <= last_k;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign m.data  = mem_data[rd_ptr];
  assign m.idx   = mem_idx[rd_ptr];
  assign m.last  = mem_last[rd_ptr];
  assign m.valid = (fifo_count != '0);
endmodule

// File: tb/tb_pe_row_drain.sv
// tb/tb_pe_row_drain.sv - self-checking bench for pe_row_drain with a PE output-chain model
module tb_pe_row_drain;
  localparam int DW = 16;
  localparam int NP = 8;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drain_start = 1'b0;
  logic drain_busy, drain_done, err_overrun;
  logic pe_en_out, pe_eject_ctrl, pe_clear_psum;
  logic [DW-1:0] chain_tail;
  logic [2:0] fifo_count;

  pe_row_drain_if #(.DW(DW), .IW(3)) m_if ();

  pe_row_drain #(.DW(DW), .N_PE(NP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .drain_start(drain_start),
    .drain_busy(drain_busy), .drain_done(drain_done), .err_overrun(err_overrun),
    .pe_en_out(pe_en_out), .pe_eject_ctrl(pe_eject_ctrl), .pe_clear_psum(pe_clear_psum),
    .chain_tail(chain_tail), .m(m_if), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // PE output-register chain: load psums or shift towards the tail, PE0 fed with 0.
  logic [DW-1:0] psum  [NP];
  logic [DW-1:0] chain [NP];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) chain[i] <= '0;
    end else if (pe_en_out) begin
      if (!pe_eject_ctrl) begin
        for (int i = 0; i < NP; i++) chain[i] <= psum[i];
      end else begin
        chain[0] <= '0;
        for (int i = 1; i < NP; i++) chain[i] <= chain[i-1];
      end
    end
  end
  assign chain_tail = chain[NP-1];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    i;
    logic          l;
  } word_t;
  word_t sb[$];

  task automatic push_tile();
    for (int k = 0; k < NP; k++) begin
      word_t w;
      w.d = psum[NP-1-k];
      w.i = 3'(NP - 1 - k);
      w.l = (k == NP - 1);
      sb.push_back(w);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!rst && m_if.valid && m_if.ready) begin
      if (sb.size() == 0) begin
        chk("stream_unexpected_word", {m_if.data, m_if.idx, m_if.last}, 0);
      end else begin
        word_t w;
        w = sb.pop_front();
        chk("stream_word", {m_if.data, m_if.idx, m_if.last}, {w.d, w.i, w.l});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!drain_done && n < budget) begin
      step();
      n++;
    end
    chk(nm, drain_done, 1);
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n = 0;
    while (m_if.valid && n < budget) begin
      step();
      n++;
    end
    chk(nm, {m_if.valid, fifo_count}, 0);
  endtask

  typedef struct {
    logic st, rdy, busy, done, en, ej, clr, vld;
    logic [DW-1:0] d;
    logic [2:0] i;
    logic l;
    logic [2:0] cnt;
  } vec_t;
  vec_t vt[11];

  initial begin
    m_if.ready = 1'b0;
    for (int i = 0; i < NP; i++) psum[i] = DW'(i + 1);

    //          st rdy bsy dn en ej clr vld data  idx last cnt
    vt[0]  = '{1, 1, 1, 0, 1, 0, 1, 0, 16'd0, 3'd0, 0, 3'd0};
    vt[1]  = '{0, 1, 1, 0, 1, 1, 0, 0, 16'd0, 3'd0, 0, 3'd0};
    vt[2]  = '{0, 1, 1, 0, 1, 1, 0, 1, 16'd8, 3'd7, 0, 3'd1};
    vt[3]  = '{0, 1, 1, 0, 1, 1, 0, 1, 16'd7, 3'd6, 0, 3'd1};
    vt[4]  = '{0, 1, 1, 0, 1, 1, 0, 1, 16'd6, 3'd5, 0, 3'd1};
    vt[5]  = '{0, 1, 1, 0, 1, 1, 0, 1, 16'd5, 3'd4, 0, 3'd1};
    vt[6]  = '{0, 1, 1, 0, 1, 1, 0, 1, 16'd4, 3'd3, 0, 3'd1};
    vt[7]  = '{0, 1, 1, 0, 1, 1, 0, 1, 16'd3, 3'd2, 0, 3'd1};
    vt[8]  = '{0, 1, 1, 0, 1, 1, 0, 1, 16'd2, 3'd1, 0, 3'd1};
    vt[9]  = '{0, 1, 0, 1, 0, 0, 0, 1, 16'd1, 3'd0, 1, 3'd1};
    vt[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 16'd0, 3'd0, 0, 3'd0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {drain_busy, drain_done, err_overrun, pe_en_out, pe_eject_ctrl,
                          pe_clear_psum, m_if.valid, fifo_count}, 0);
    rst = 1'b0;
    step();

    // Basic drain with cycle-exact timing, one vector per cycle after the start edge.
    push_tile();
    for (int j = 0; j < 11; j++) begin
      drain_start = vt[j].st;
      m_if.ready  = vt[j].rdy;
      step();
      chk($sformatf("cycle_%0d", j + 1),
          {drain_busy, drain_done, err_overrun, pe_en_out, pe_eject_ctrl, pe_clear_psum, m_if.valid,
           m_if.valid ? m_if.data : 16'd0, m_if.valid ? m_if.idx : 3'd0,
           m_if.valid ? m_if.last : 1'b0, fifo_count},
          {vt[j].busy, vt[j].done, 1'b0, vt[j].en, vt[j].ej, vt[j].clr, vt[j].vld,
           vt[j].d, vt[j].i, vt[j].l, vt[j].cnt});
    end
    drain_start = 1'b0;

    // Full FIFO with the sink blocked: chain must stall and hold.
    for (int i = 0; i < NP; i++) psum[i] = DW'(16'h0100 + i);
    m_if.ready  = 1'b0;
    drain_start = 1'b1;
    push_tile();
    step();
    drain_start = 1'b0;
    repeat (5) step();
    chk("stall_at_full", {pe_en_out, drain_busy, fifo_count}, {1'b0, 1'b1, 3'd4});
    repeat (3) step();
    chk("stall_holds", {pe_en_out, drain_busy, fifo_count}, {1'b0, 1'b1, 3'd4});
    m_if.ready = 1'b1;
    wait_done("stall_done", 40);
    wait_empty("stall_empty", 20);

    // Overrun start during SHIFT, then back-to-back start in the done cycle.
    for (int i = 0; i < NP; i++) psum[i] = DW'(16'h1000 * (i + 1) + 16'h0033);
    drain_start = 1'b1;
    push_tile();
    step();
    drain_start = 1'b0;
    step();
    step();
    drain_start = 1'b1;
    step();
    chk("err_overrun_pulse", {err_overrun, drain_busy}, 2'b11);
    drain_start = 1'b0;
    step();
    chk("err_overrun_clears", {err_overrun, drain_busy}, 2'b01);
    wait_done("overrun_done", 20);
    drain_start = 1'b1;
    push_tile();
    step();
    chk("b2b_load", {drain_busy, pe_clear_psum, pe_en_out, pe_eject_ctrl, err_overrun}, 5'b11100);
    drain_start = 1'b0;
    step();
    chk("b2b_clear_one_cycle", {pe_clear_psum, pe_eject_ctrl}, 2'b01);
    wait_done("b2b_done", 20);
    wait_empty("b2b_empty", 20);

    // Negative psums bit-exact, and simultaneous push+pop at count 2.
    psum[0] = 16'hFFFF;
    psum[1] = 16'h8000;
    psum[2] = 16'h7FFF;
    psum[3] = 16'h8001;
    psum[4] = 16'hFFFE;
    psum[5] = 16'h0000;
    psum[6] = 16'hC000;
    psum[7] = 16'hFF80;
    m_if.ready  = 1'b0;
    drain_start = 1'b1;
    push_tile();
    step();
    drain_start = 1'b0;
    repeat (3) step();
    chk("count_before_pushpop", fifo_count, 3'd2);
    m_if.ready = 1'b1;
    step();
    chk("count_after_pushpop", fifo_count, 3'd2);
    wait_done("neg_done", 20);
    wait_empty("neg_empty", 20);

    // Asynchronous reset mid-SHIFT at k=3.
    m_if.ready  = 1'b0;
    drain_start = 1'b1;
    push_tile();
    step();
    drain_start = 1'b0;
    repeat (4) step();
    chk("pre_reset_busy", {drain_busy, fifo_count}, {1'b1, 3'd3});
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_reset", {m_if.valid, drain_busy, drain_done, pe_en_out, pe_eject_ctrl,
                        pe_clear_psum, fifo_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_if.ready = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", {m_if.valid, drain_busy, drain_done, pe_en_out, fifo_count}, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
